// File: rtl/mdu_hilo.sv
// Multiply/divide unit holding the MIPS HI/LO registers. The result is computed
// in one shot at issue and then held back by a countdown to model real latency.
module mdu_hilo #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_start,
   input  logic [2:0]  md_op,
   input  logic [31:0] md_src_a,
   input  logic [31:0] md_src_b,
   output logic        md_busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t        state;
   logic [CW-1:0] counter;
   logic [31:0]   pending_hi;
   logic [31:0]   pending_lo;

   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   abs_a;
   logic [31:0]   abs_b;
   logic [31:0]   mag_q;
   logic [31:0]   mag_r;
   logic [31:0]   udiv_q;
   logic [31:0]   udiv_r;
   logic [31:0]   sdiv_q;
   logic [31:0]   sdiv_r;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;

   // Signed division works on magnitudes; 0x80000000 keeps its bit pattern when
   // negated, which is still the correct unsigned magnitude, so the overflow case
   // 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
   always_comb begin
      prod_s = {{32{md_src_a[31]}}, md_src_a} * {{32{md_src_b[31]}}, md_src_b};
      prod_u = {32'd0, md_src_a} * {32'd0, md_src_b};
      abs_a  = md_src_a[31] ? (~md_src_a + 32'd1) : md_src_a;
      abs_b  = md_src_b[31] ? (~md_src_b + 32'd1) : md_src_b;
      mag_q  = 32'd0;
      mag_r  = 32'd0;
      udiv_q = 32'd0;
      udiv_r = 32'd0;
      if (md_src_b != 32'd0) begin
         mag_q  = abs_a / abs_b;
         mag_r  = abs_a % abs_b;
         udiv_q = md_src_a / md_src_b;
         udiv_r = md_src_a % md_src_b;
      end
      sdiv_q = (md_src_a[31] ^ md_src_b[31]) ? (~mag_q + 32'd1) : mag_q;
      sdiv_r = md_src_a[31] ? (~mag_r + 32'd1) : mag_r;
   end

   // Divide by zero still pays full latency and yields lo=all ones, hi=dividend.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (md_op)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            if (md_src_b == 32'd0) begin
               res_hi = md_src_a;
               res_lo = 32'hFFFF_FFFF;
            end else if (md_op == OP_DIV) begin
               res_hi = sdiv_r;
               res_lo = sdiv_q;
            end else begin
               res_hi = udiv_r;
               res_lo = udiv_q;
            end
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

   // Starts are only honoured in IDLE, so a request landing on the completion
   // edge is dropped because the unit is still BUSY at that edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         counter    <= '0;
         md_busy    <= 1'b0;
         hi         <= 32'd0;
         lo         <= 32'd0;
         pending_hi <= 32'd0;
         pending_lo <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (md_start) begin
                  case (md_op)
                     OP_MULT, OP_MULTU: begin
                        pending_hi <= res_hi;
                        pending_lo <= res_lo;
                        counter    <= CW'(MULT_CYCLES);
                        md_busy    <= 1'b1;
                        state      <= BUSY;
                     end
                     OP_DIV, OP_DIVU: begin
                        pending_hi <= res_hi;
                        pending_lo <= res_lo;
                        counter    <= CW'(DIV_CYCLES);
                        md_busy    <= 1'b1;
                        state      <= BUSY;
                     end
                     OP_MTHI: hi <= md_src_a;
                     OP_MTLO: lo <= md_src_a;
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               if (counter == CW'(1)) begin
                  hi      <= pending_hi;
                  lo      <= pending_lo;
                  counter <= '0;
                  md_busy <= 1'b0;
                  state   <= IDLE;
               end else begin
                  counter <= counter - CW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               md_busy <= 1'b0;
               counter <= '0;
            end
         endcase
      end
   end

endmodule
